// File: rtl/fsm_vector_sequencer_if.sv
// Host-side bus of the vector sequencer: queue load handshake, run control
// and run results.
//
// Parameters must match the sequencer instance they connect to:
//   DEPTH  queue entries (power of two, 2..64)
//   CNT_W  width of the mismatch counter
//
// Signals:
//   clear        host -> seq  empty the queue (IDLE only)
//   load_valid   host -> seq  a load entry is offered
//   load_ready   seq -> host  the queue can accept an entry
//   load_vec     host -> seq  input vector, bit0 = x1 .. bit4 = x5
//   load_exp     host -> seq  expected outputs, bit0 = y1 .. bit24 = y25
//   start        host -> seq  begin a run (IDLE only)
//   busy         seq -> host  a run is in progress
//   done         seq -> host  one-cycle pulse, results valid from here on
//   pass         seq -> host  last run had zero mismatches
//   mismatch_cnt seq -> host  mismatching entries in the last run
//   fail_idx     seq -> host  index of the first mismatch, 0 if none
//   signature    seq -> host  MISR over the captured outputs
interface fsm_vector_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  logic                     clear;
  logic                     load_valid;
  logic                     load_ready;
  logic [4:0]               load_vec;
  logic [24:0]              load_exp;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [CNT_W-1:0]         mismatch_cnt;
  logic [$clog2(DEPTH)-1:0] fail_idx;
  logic [24:0]              signature;

  modport master (
    output clear, load_valid, load_vec, load_exp, start,
    input  load_ready, busy, done, pass, mismatch_cnt, fail_idx, signature
  );

  modport slave (
    input  clear, load_valid, load_vec, load_exp, start,
    output load_ready, busy, done, pass, mismatch_cnt, fail_idx, signature
  );
endinterface

// File: rtl/fsm_vector_sequencer.sv
// Test sequencer for one benchmark controller FSM (x1..x5 in, y1..y25 out).
// Holds a queue of {vector, expected response} entries, resets the FSM for
// two cycles, drives one vector per cycle and compares the FSM outputs
// against the expected responses. The queue is read without popping, so a
// loaded queue can be rerun any number of times.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-low reset
//   host     fsm_vector_sequencer_if.slave: load handshake, control, results
//   dut_rst  active-high reset to the controlled FSM
//   dut_x    vector driven to the controlled FSM
//   dut_y    outputs of the controlled FSM
//
// Build option:
//   SEQ_SIGNATURE_EN  when defined, signature is a 25-bit MISR
//                     (x^25+x^3+1) over dut_y during RUN; otherwise it is
//                     tied to 0 and no MISR is built.
module fsm_vector_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  fsm_vector_sequencer_if.slave    host,
  output logic                     dut_rst,
  output logic [4:0]               dut_x,
  input  logic [24:0]              dut_y
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRST, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             drst_cnt_q, drst_cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    run_len_q, run_len_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [IW-1:0]    fail_q, fail_d;
  logic             dut_rst_q, dut_rst_d;
  logic [4:0]       dut_x_q, dut_x_d;
  logic             mismatch;
  logic             load_fire;
`ifdef SEQ_SIGNATURE_EN
  logic [24:0]      sig_q, sig_d;
`endif

  logic [4:0]       vec_mem [DEPTH];
  logic [24:0]      exp_mem [DEPTH];

  // clear wins over a load in the same cycle by dropping load_ready;
  // gating with rst keeps load_ready low while reset is held.
  assign host.load_ready = rst && (state_q == S_IDLE) &&
                           (count_q < CW'(DEPTH)) && !host.clear;
  assign load_fire       = host.load_valid && host.load_ready;

  // Queue storage needs no reset; only entries below count_q are ever read.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      vec_mem[count_q[IW-1:0]] <= host.load_vec;
      exp_mem[count_q[IW-1:0]] <= host.load_exp;
    end
  end

  always_comb begin
    state_d    = state_q;
    drst_cnt_d = drst_cnt_q;
    count_d    = count_q;
    run_len_d  = run_len_q;
    rd_idx_d   = rd_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    mis_d      = mis_q;
    fail_d     = fail_q;
    dut_rst_d  = dut_rst_q;
    dut_x_d    = dut_x_q;
    mismatch   = 1'b0;
`ifdef SEQ_SIGNATURE_EN
    sig_d      = sig_q;
`endif

    if ((state_q == S_IDLE) && host.clear) begin
      count_d = '0;
    end else if (load_fire) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        busy_d    = 1'b0;
        dut_rst_d = 1'b1;
        dut_x_d   = '0;
        if (host.start) begin
          // Run length is the count before any load accepted this cycle.
          run_len_d  = count_q;
          rd_idx_d   = '0;
          drst_cnt_d = 1'b0;
          mis_d      = '0;
          fail_d     = '0;
`ifdef SEQ_SIGNATURE_EN
          sig_d      = '0;
`endif
          if (count_q == '0) begin
            // Empty queue: report a trivial pass without touching the FSM.
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_DRST;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end

      S_DRST: begin
        if (drst_cnt_q) begin
          state_d   = S_RUN;
          dut_rst_d = 1'b0;
          dut_x_d   = vec_mem[0];
        end else begin
          drst_cnt_d = 1'b1;
        end
      end

      S_RUN: begin
        // dut_y at this edge is the response to the vector driven this cycle.
        mismatch = (dut_y != exp_mem[rd_idx_q]);
        if (mismatch) begin
          if (mis_q != '1) begin
            mis_d = mis_q + 1'b1;
          end
          if (mis_q == '0) begin
            fail_d = rd_idx_q;
          end
        end
`ifdef SEQ_SIGNATURE_EN
        sig_d = {sig_q[23:0], sig_q[24] ^ sig_q[2]} ^ dut_y;
`endif
        if (CW'(rd_idx_q) == run_len_q - 1'b1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          dut_x_d = '0;
          pass_d  = (mis_d == '0);
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
          dut_x_d  = vec_mem[rd_idx_d];
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        dut_rst_d = 1'b1;
        dut_x_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      drst_cnt_q <= 1'b0;
      count_q    <= '0;
      run_len_q  <= '0;
      rd_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mis_q      <= '0;
      fail_q     <= '0;
      dut_rst_q  <= 1'b1;
      dut_x_q    <= '0;
`ifdef SEQ_SIGNATURE_EN
      sig_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      drst_cnt_q <= drst_cnt_d;
      count_q    <= count_d;
      run_len_q  <= run_len_d;
      rd_idx_q   <= rd_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mis_q      <= mis_d;
      fail_q     <= fail_d;
      dut_rst_q  <= dut_rst_d;
      dut_x_q    <= dut_x_d;
`ifdef SEQ_SIGNATURE_EN
      sig_q      <= sig_d;
`endif
    end
  end

  assign host.busy         = busy_q;
  assign host.done         = done_q;
  assign host.pass         = pass_q;
  assign host.mismatch_cnt = mis_q;
  assign host.fail_idx     = fail_q;
`ifdef SEQ_SIGNATURE_EN
  assign host.signature    = sig_q;
`else
  assign host.signature    = '0;
`endif
  assign dut_rst           = dut_rst_q;
  assign dut_x             = dut_x_q;

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Self-checking bench for fsm_vector_sequencer. The controlled FSM is
// modelled as a loopback (dut_y = {20'b0, dut_x}). Hand-computed table
// scenarios, corner-case sequences and random queues are checked against a
// queue-based reference model of the run results.
module tb_fsm_vector_sequencer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dut_rst;
  logic [4:0]  dut_x;
  logic [24:0] dut_y;

  int total = 0;
  int bad   = 0;

  logic [4:0]  m_vec [$];
  logic [24:0] m_exp [$];

  always #5 clk = ~clk;

  fsm_vector_sequencer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) host ();

  assign dut_y = {20'b0, dut_x};

  fsm_vector_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host),
    .dut_rst (dut_rst),
    .dut_x   (dut_x),
    .dut_y   (dut_y)
  );

  typedef struct {
    int               n;
    logic [3:0][4:0]  vec;
    logic [3:0][24:0] exp;
    int               mis;
    int               fidx;
    int               pass_e;
    logic [24:0]      sig_e;
  } vec_rec_t;

  vec_rec_t tbl [4];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Results the first n queued entries must produce under loopback.
  task automatic modelResults(input int n, output int mis, output int fidx,
                              output logic [24:0] sig);
    logic [24:0] y;
    logic        fb;
    mis  = 0;
    fidx = 0;
    sig  = '0;
    for (int i = 0; i < n; i++) begin
      y = {20'b0, m_vec[i]};
      if (y != m_exp[i]) begin
        if (mis == 0) fidx = i;
        mis = (mis >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : mis + 1;
      end
      fb  = sig[24] ^ sig[2];
      sig = ((sig << 1) | 25'(fb)) ^ y;
    end
`ifndef SEQ_SIGNATURE_EN
    sig = '0;
`endif
  endtask

  task automatic doClear;
    @(negedge clk);
    host.clear = 1'b1;
    @(posedge clk);
    #1 host.clear = 1'b0;
    m_vec.delete();
    m_exp.delete();
  endtask

  task automatic applyStimulus(input logic [4:0] v, input logic [24:0] e);
    @(negedge clk);
    host.load_valid = 1'b1;
    host.load_vec   = v;
    host.load_exp   = e;
    checkOutput("load_ready", 32'(host.load_ready), 32'(m_vec.size() < DEPTH));
    @(posedge clk);
    #1 host.load_valid = 1'b0;
    if (m_vec.size() < DEPTH) begin
      m_vec.push_back(v);
      m_exp.push_back(e);
    end
  endtask

  task automatic pulseStart;
    @(negedge clk);
    host.start = 1'b1;
    @(posedge clk);
    #1 host.start = 1'b0;
  endtask

  // Called right after the edge that sampled start; walks C1.. to done.
  task automatic waitDone(input string tag, input int n);
    int          lat;
    bit          sched_ok;
    int          e_mis;
    int          e_fidx;
    logic [24:0] e_sig;
    lat      = 0;
    sched_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (n == 0) begin
        if (dut_rst !== 1'b1) sched_ok = 1'b0;
      end else if (k <= 2) begin
        if (dut_rst !== 1'b1 || host.busy !== 1'b1 || dut_x !== 5'd0) sched_ok = 1'b0;
      end else if (k < 3 + n) begin
        if (dut_rst !== 1'b0 || host.busy !== 1'b1 || dut_x !== m_vec[k-3]) sched_ok = 1'b0;
      end
      if (host.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, ":latency"}, 32'(lat), 32'((n == 0) ? 1 : n + 3));
    if (lat != 0) begin
      modelResults(n, e_mis, e_fidx, e_sig);
      checkOutput({tag, ":schedule"}, 32'(sched_ok), 32'd1);
      checkOutput({tag, ":busy@done"}, 32'(host.busy), 32'd0);
      checkOutput({tag, ":dut_x@done"}, 32'(dut_x), 32'd0);
      checkOutput({tag, ":dut_rst@done"}, 32'(dut_rst), 32'((n == 0) ? 1 : 0));
      checkOutput({tag, ":mismatch_cnt"}, 32'(host.mismatch_cnt), 32'(e_mis));
      checkOutput({tag, ":fail_idx"}, 32'(host.fail_idx), 32'(e_fidx));
      checkOutput({tag, ":pass"}, 32'(host.pass), 32'(e_mis == 0));
      checkOutput({tag, ":signature"}, 32'(host.signature), 32'(e_sig));
      @(negedge clk);
      checkOutput({tag, ":done_pulse"}, 32'(host.done), 32'd0);
      checkOutput({tag, ":ready_after"}, 32'(host.load_ready),
                  32'(m_vec.size() < DEPTH));
    end
  endtask

  task automatic runSeq(input string tag, input int n);
    pulseStart();
    waitDone(tag, n);
  endtask

  initial begin
    bit          ok;
    logic [4:0]  v;
    logic [24:0] e;
    int          n;

    host.clear      = 1'b0;
    host.load_valid = 1'b0;
    host.load_vec   = '0;
    host.load_exp   = '0;
    host.start      = 1'b0;

    tbl[0] = '{n: 4, vec: {5'd4, 5'd3, 5'd2, 5'd1},
               exp: {25'd4, 25'd3, 25'd2, 25'd1},
               mis: 0, fidx: 0, pass_e: 1, sig_e: 25'h2};
    tbl[1] = '{n: 4, vec: {5'd4, 5'd3, 5'd2, 5'd1},
               exp: {25'd0, 25'd3, 25'h1FFFFFF, 25'd1},
               mis: 2, fidx: 1, pass_e: 0, sig_e: 25'h2};
    tbl[2] = '{n: 1, vec: {5'd0, 5'd0, 5'd0, 5'd1},
               exp: {25'd0, 25'd0, 25'd0, 25'd1},
               mis: 0, fidx: 0, pass_e: 1, sig_e: 25'h1};
    tbl[3] = '{n: 3, vec: {5'd0, 5'd7, 5'd6, 5'd5},
               exp: {25'd0, 25'd0, 25'd6, 25'd5},
               mis: 1, fidx: 2, pass_e: 0, sig_e: 25'h1C};

    // Reset state while rst is held low.
    repeat (2) @(negedge clk);
    checkOutput("rst:load_ready", 32'(host.load_ready), 32'd0);
    checkOutput("rst:busy", 32'(host.busy), 32'd0);
    checkOutput("rst:done", 32'(host.done), 32'd0);
    checkOutput("rst:pass", 32'(host.pass), 32'd0);
    checkOutput("rst:mismatch_cnt", 32'(host.mismatch_cnt), 32'd0);
    checkOutput("rst:signature", 32'(host.signature), 32'd0);
    checkOutput("rst:dut_rst", 32'(dut_rst), 32'd1);
    checkOutput("rst:dut_x", 32'(dut_x), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst:ready_release", 32'(host.load_ready), 32'd1);

    // Hand-computed table scenarios.
    for (int t = 0; t < 4; t++) begin
      doClear();
      for (int j = 0; j < tbl[t].n; j++) applyStimulus(tbl[t].vec[j], tbl[t].exp[j]);
      runSeq($sformatf("tbl%0d", t), tbl[t].n);
      checkOutput($sformatf("tbl%0d:mis_const", t), 32'(host.mismatch_cnt), 32'(tbl[t].mis));
      checkOutput($sformatf("tbl%0d:fidx_const", t), 32'(host.fail_idx), 32'(tbl[t].fidx));
      checkOutput($sformatf("tbl%0d:pass_const", t), 32'(host.pass), 32'(tbl[t].pass_e));
`ifdef SEQ_SIGNATURE_EN
      checkOutput($sformatf("tbl%0d:sig_const", t), 32'(host.signature), 32'(tbl[t].sig_e));
`else
      checkOutput($sformatf("tbl%0d:sig_const", t), 32'(host.signature), 32'd0);
`endif
    end

    // Rerun the retained queue without reloading.
    runSeq("rerun", 3);
    checkOutput("rerun:fidx_const", 32'(host.fail_idx), 32'd2);

    // Fill to DEPTH; the 9th offer must be refused.
    doClear();
    for (int j = 0; j < DEPTH; j++) applyStimulus(5'(j + 1), 25'(j + 1));
    @(negedge clk);
    checkOutput("full:load_ready", 32'(host.load_ready), 32'd0);
    applyStimulus(5'd31, 25'd0);
    runSeq("full", DEPTH);

    // Empty queue start.
    doClear();
    runSeq("empty", 0);

    // Start and load in the same cycle: run uses the pre-load count.
    doClear();
    applyStimulus(5'd9, 25'd9);
    applyStimulus(5'd10, 25'd3);
    @(negedge clk);
    host.load_valid = 1'b1;
    host.load_vec   = 5'd11;
    host.load_exp   = 25'd0;
    host.start      = 1'b1;
    @(posedge clk);
    #1;
    host.load_valid = 1'b0;
    host.start      = 1'b0;
    m_vec.push_back(5'd11);
    m_exp.push_back(25'd0);
    waitDone("ld_start", 2);
    runSeq("ld_start2", 3);

    // Reset in C4 of a 6-entry run.
    doClear();
    for (int j = 0; j < 6; j++) applyStimulus(5'(j + 3), 25'(j));
    pulseStart();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst:busy", 32'(host.busy), 32'd0);
    checkOutput("midrst:done", 32'(host.done), 32'd0);
    checkOutput("midrst:mismatch_cnt", 32'(host.mismatch_cnt), 32'd0);
    checkOutput("midrst:fail_idx", 32'(host.fail_idx), 32'd0);
    checkOutput("midrst:dut_rst", 32'(dut_rst), 32'd1);
    checkOutput("midrst:dut_x", 32'(dut_x), 32'd0);
    checkOutput("midrst:load_ready", 32'(host.load_ready), 32'd0);
    rst = 1'b1;
    m_vec.delete();
    m_exp.delete();
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (host.done !== 1'b0) ok = 1'b0;
    end
    checkOutput("midrst:no_done", 32'(ok), 32'd1);
    checkOutput("midrst:ready_after", 32'(host.load_ready), 32'd1);
    runSeq("midrst:count0", 0);

    // Random queues against the reference model.
    for (int r = 0; r < 8; r++) begin
      doClear();
      n = $urandom_range(0, DEPTH);
      for (int j = 0; j < n; j++) begin
        v = 5'($urandom);
        e = ($urandom_range(0, 1) == 1) ? {20'b0, v} : 25'($urandom);
        applyStimulus(v, e);
      end
      runSeq($sformatf("rand%0d", r), n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
